// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: decodes a 16-bit instruction, reads two operands from the register file, and registers the result toward execute.
// Latency is 1 cycle. A pending-write scoreboard stalls the input on RAW/WAW hazards, and flush/backpressure hold off new input.
// Optional macro OPF_WB_BYPASS_EN forwards same-cycle writeback data into a stalled source.
module operand_fetch #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic [2:0]      read_reg1,
    output logic [2:0]      read_reg2,
    input  logic [15:0]     reg1,
    input  logic [15:0]     reg2,
    input  logic            wb_wr_en,
    input  logic [2:0]      wb_reg,
    input  logic [15:0]     wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_op,
    output logic [2:0]      out_rd,
    output logic            out_wr,
    output logic [15:0]     out_a,
    output logic [15:0]     out_b,
    output logic [15:0]     out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;

    logic [3:0]  dec_op;
    logic [2:0]  dec_rd;
    logic [2:0]  dec_rs1;
    logic [2:0]  dec_rs2;
    logic        dec_use1;
    logic        dec_use2;
    logic        dec_wr;
    logic        dec_illegal;
    logic [15:0] dec_imm;

    logic [7:0]      pend_q, pend_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      out_op_q, out_op_d;
    logic [2:0]      out_rd_q, out_rd_d;
    logic            out_wr_q, out_wr_d;
    logic [15:0]     out_a_q, out_a_d;
    logic [15:0]     out_b_q, out_b_d;
    logic [15:0]     out_imm_q, out_imm_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;
    logic            out_illegal_q, out_illegal_d;

    logic byp1, byp2;
    logic haz1, haz2, haz_waw, hazard;
    logic accept, leave;

    assign dec_op    = in_instr[15:12];
    assign dec_rd    = in_instr[11:9];
    assign dec_rs1   = in_instr[8:6];
    assign dec_rs2   = in_instr[5:3];
    assign read_reg1 = dec_rs1;
    assign read_reg2 = dec_rs2;

    always_comb begin
        dec_use1    = 1'b0;
        dec_use2    = 1'b0;
        dec_wr      = 1'b0;
        dec_illegal = 1'b0;
        dec_imm     = {{10{in_instr[5]}}, in_instr[5:0]};
        case (dec_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec_use1 = 1'b1;
                dec_use2 = 1'b1;
                dec_wr   = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                dec_use1 = 1'b1;
                dec_wr   = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                dec_use1 = 1'b1;
                dec_use2 = 1'b1;
            end
            OP_JMP:  dec_imm = {{4{in_instr[11]}}, in_instr[11:0]};
            4'd9:    dec_illegal = 1'b0;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Same-cycle writeback to a pending source can stand in for the stale register file read.
`ifdef OPF_WB_BYPASS_EN
    assign byp1 = pend_q[dec_rs1] & wb_wr_en & (wb_reg == dec_rs1);
    assign byp2 = pend_q[dec_rs2] & wb_wr_en & (wb_reg == dec_rs2);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // The instruction sitting in the output register has not set its pending bit yet.
    assign haz1 = dec_use1 & ((pend_q[dec_rs1] & !byp1) |
                  (out_valid_q & out_wr_q & (out_rd_q == dec_rs1)));
    assign haz2 = dec_use2 & ((pend_q[dec_rs2] & !byp2) |
                  (out_valid_q & out_wr_q & (out_rd_q == dec_rs2)));
    assign haz_waw = dec_wr & pend_q[dec_rd];
    assign hazard  = haz1 | haz2 | haz_waw;

    assign in_ready = !hazard & !flush & (!out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign leave    = out_valid_q & out_ready & !flush;

    always_comb begin
        pend_d = pend_q;
        if (wb_wr_en)
            pend_d[wb_reg] = 1'b0;
        if (leave & out_wr_q)
            pend_d[out_rd_q] = 1'b1;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        out_rd_d      = out_rd_q;
        out_wr_d      = out_wr_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_imm_d     = out_imm_q;
        out_pc_d      = out_pc_q;
        out_illegal_d = out_illegal_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_op_d      = dec_op;
            out_rd_d      = dec_rd;
            out_wr_d      = dec_wr;
            out_a_d       = !dec_use1 ? 16'h0000 : (byp1 ? wb_data : reg1);
            out_b_d       = !dec_use2 ? 16'h0000 : (byp2 ? wb_data : reg2);
            out_imm_d     = dec_imm;
            out_pc_d      = in_pc;
            out_illegal_d = dec_illegal;
        end else if (flush | (out_valid_q & out_ready)) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= '0;
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_rd_q      <= '0;
            out_wr_q      <= 1'b0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_imm_q     <= '0;
            out_pc_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            out_rd_q      <= out_rd_d;
            out_wr_q      <= out_wr_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_imm_q     <= out_imm_d;
            out_pc_q      <= out_pc_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_rd      = out_rd_q;
    assign out_wr      = out_wr_q;
    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: decode, hazard stalls, backpressure, flush and reset.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [7:0]  in_pc;
    logic [2:0]  read_reg1, read_reg2;
    logic [15:0] reg1, reg2;
    logic        wb_wr_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [3:0]  out_op;
    logic [2:0]  out_rd;
    logic        out_wr;
    logic [15:0] out_a, out_b, out_imm;
    logic [7:0]  out_pc;
    logic        out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    operand_fetch #(.PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .reg1(reg1), .reg2(reg2),
        .wb_wr_en(wb_wr_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
        .out_wr(out_wr), .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h9000; in_pc = '0;
        reg1 = '0; reg2 = '0; wb_wr_en = 1'b0; wb_reg = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_pend", dut.pend_q, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD r4,r1,r2
        in_valid = 1'b1; in_instr = 16'h0850; in_pc = 8'h10; reg1 = 16'h0001; reg2 = 16'h0002;
        #1;
        chk("add_in_ready", in_ready, 1);
        chk("add_rr1", read_reg1, 1);
        chk("add_rr2", read_reg2, 2);
        tick();
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_op", out_op, 0);
        chk("add_rd", out_rd, 4);
        chk("add_a", out_a, 16'h0001);
        chk("add_b", out_b, 16'h0002);
        chk("add_wr", out_wr, 1);
        chk("add_pc", out_pc, 8'h10);
        chk("add_blocked_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("add_drained", out_valid, 0);
        chk("add_pend", dut.pend_q, 8'h10);

        // ADDI r5,r3,-2
        in_valid = 1'b1; in_instr = 16'h4AFE; in_pc = 8'h11; reg1 = 16'h1234; reg2 = 16'h5555;
        #1;
        chk("addi_in_ready", in_ready, 1);
        tick();
        chk("addi_op", out_op, 4);
        chk("addi_rd", out_rd, 5);
        chk("addi_a", out_a, 16'h1234);
        chk("addi_b", out_b, 16'h0000);
        chk("addi_imm", out_imm, 16'hFFFE);
        chk("addi_wr", out_wr, 1);
        chk("addi_illegal", out_illegal, 0);

        // Opcode 12, back-to-back with ADDI draining
        in_instr = 16'hC000; in_pc = 8'h12;
        #1;
        chk("ill_in_ready", in_ready, 1);
        tick();
        chk("ill_illegal", out_illegal, 1);
        chk("ill_wr", out_wr, 0);
        chk("ill_op", out_op, 12);
        chk("ill_a", out_a, 0);
        chk("ill_b", out_b, 0);
        chk("ill_pend", dut.pend_q, 8'h30);

        // JMP with negative imm12, writeback r5 in the same cycle
        in_instr = 16'h8800; in_pc = 8'h13; wb_wr_en = 1'b1; wb_reg = 3'd5;
        #1;
        chk("jmp_in_ready", in_ready, 1);
        tick();
        wb_wr_en = 1'b0;
        chk("jmp_op", out_op, 8);
        chk("jmp_imm", out_imm, 16'hF800);
        chk("jmp_wr", out_wr, 0);
        chk("jmp_illegal", out_illegal, 0);
        chk("jmp_pend", dut.pend_q, 8'h10);

        // SUB r6,r4,r1 stalls on pending r4
        in_instr = 16'h1D08; in_pc = 8'h20; reg1 = 16'h0007; reg2 = 16'h0003;
        #1;
        chk("raw_stall0", in_ready, 0);
        tick();
        chk("raw_out_empty", out_valid, 0);
        chk("raw_stall1", in_ready, 0);
        wb_wr_en = 1'b1; wb_reg = 3'd4; wb_data = 16'hBEEF;
        #1;
`ifdef OPF_WB_BYPASS_EN
        chk("raw_wb_ready", in_ready, 1);
        tick();
        wb_wr_en = 1'b0; reg1 = 16'hBEEF;
`else
        chk("raw_wb_ready", in_ready, 0);
        tick();
        wb_wr_en = 1'b0; reg1 = 16'hBEEF;
        #1;
        chk("raw_after_wb_ready", in_ready, 1);
        tick();
`endif
        out_ready = 1'b0; in_instr = 16'h2E98; in_pc = 8'h21; reg1 = 16'h00AA; reg2 = 16'h00BB;
        chk("sub_valid", out_valid, 1);
        chk("sub_rd", out_rd, 6);
        chk("sub_a", out_a, 16'hBEEF);
        chk("sub_b", out_b, 16'h0003);
        chk("sub_pc", out_pc, 8'h20);
        chk("sub_pend", dut.pend_q, 0);

        // Backpressure for three cycles
        #1;
        chk("bp_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_rd", out_rd, 6);
            chk("bp_a", out_a, 16'hBEEF);
            chk("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("drain_rd", out_rd, 7);
        chk("drain_a", out_a, 16'h00AA);
        chk("drain_b", out_b, 16'h00BB);
        chk("drain_pend", dut.pend_q, 8'h40);
        tick();
        chk("drain_empty", out_valid, 0);
        chk("drain_pend2", dut.pend_q, 8'hC0);

        // Flush kills the held instruction without touching the scoreboard
        in_valid = 1'b1; in_instr = 16'h0298; in_pc = 8'h30; out_ready = 1'b0;
        #1;
        chk("fl_in_ready", in_ready, 1);
        tick();
        chk("fl_loaded", out_valid, 1);
        chk("fl_rd", out_rd, 1);
        flush = 1'b1; out_ready = 1'b1; in_instr = 16'h9000;
        #1;
        chk("fl_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_killed", out_valid, 0);
        chk("fl_pend", dut.pend_q, 8'hC0);

        // Build pending = 0x10 with SUB r6,r4,r1 stalled
        wb_wr_en = 1'b1; wb_reg = 3'd6;
        tick();
        wb_reg = 3'd7; in_valid = 1'b1; in_instr = 16'h0850; reg1 = 16'h0001; reg2 = 16'h0002;
        #1;
        chk("pre_add_ready", in_ready, 1);
        tick();
        wb_wr_en = 1'b0; in_instr = 16'h1D08; reg1 = 16'h0005;
        #1;
        chk("inflight_stall", in_ready, 0);
        tick();
        chk("pre_rst_pend", dut.pend_q, 8'h10);
        chk("pre_rst_stall", in_ready, 0);
        chk("pre_rst_valid", out_valid, 0);

        // Reset mid-stall
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pend", dut.pend_q, 0);
        chk("mid_rst_valid", out_valid, 0);
        reg1 = 16'h0042;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_op", out_op, 1);
        chk("post_rst_rd", out_rd, 6);
        chk("post_rst_a", out_a, 16'h0042);

        // Set and clear of the same bit in one cycle: set wins
        wb_wr_en = 1'b1; wb_reg = 3'd6;
        tick();
        wb_wr_en = 1'b0;
        chk("set_wins", dut.pend_q, 8'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
